// File: rtl/opb_register_simulink2ppc_snap_pkg.sv
// Shared definitions for the simulink-to-PPC snapshot register:
// word map, STATUS layout and OPB slave FSM states.
package opb_register_simulink2ppc_snap_pkg;

  localparam logic [1:0] WORD_DATA   = 2'd0;
  localparam logic [1:0] WORD_STATUS = 2'd1;
  localparam logic [1:0] WORD_COUNT  = 2'd2;

  localparam int STATUS_FRESH_BIT = 0;
  localparam int STATUS_OVR_LSB   = 16;
  localparam int OVR_W            = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } slv_state_e;

  // Transfer attributes captured when the slave accepts a transfer.
  typedef struct packed {
    logic [1:0] word;
    logic       rnw;
    logic       be_any;
  } opb_req_t;

  function automatic logic [31:0] status_word(input logic [OVR_W-1:0] ovr,
                                              input logic fresh);
    logic [31:0] s;
    s = '0;
    s[STATUS_OVR_LSB +: OVR_W] = ovr;
    s[STATUS_FRESH_BIT]        = fresh;
    return s;
  endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_snap_ack_fsm.sv
// OPB address decode and the IDLE/ACK/GAP handshake: one registered ack
// per hit transfer, followed by a dead cycle so a held select is not re-acked.
module opb_slave_ack_fsm
  import opb_register_simulink2ppc_snap_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01180100,
  parameter logic [31:0] C_HIGHADDR   = 32'h011801FF,
  parameter int          C_OPB_AWIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [0:C_OPB_AWIDTH-1] addr_i,
  input  logic                    select_i,
  input  logic                    rnw_i,
  input  logic                    be_any_i,
  output logic                    start_o,
  output logic                    xfer_ack_o,
  output opb_req_t                req_o
);

  slv_state_e state_q;
  logic       ack_q;
  opb_req_t   req_q;
  logic       hit;

  assign hit     = (addr_i >= C_BASEADDR) && (addr_i <= C_HIGHADDR);
  assign start_o = (state_q == ST_IDLE) && select_i && hit;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      req_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          if (start_o) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            // Bits [28:29] of the big-endian address select the word.
            req_q   <= '{word: addr_i[C_OPB_AWIDTH-4 +: 2], rnw: rnw_i, be_any: be_any_i};
          end
        end
        ST_ACK: begin
          state_q <= ST_GAP;
          ack_q   <= 1'b0;
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign xfer_ack_o = ack_q;
  assign req_o      = req_q;

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// Publishes a fabric word to the PPC over OPB: DATA snapshot, STATUS
// (fresh flag + overrun count) and a free-running capture counter.
module opb_register_simulink2ppc_snap
  import opb_register_simulink2ppc_snap_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01180100,
  parameter logic [31:0] C_HIGHADDR   = 32'h011801FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  input  logic [31:0]               user_data_in,
  input  logic                      user_valid,
  output logic                      user_rd_ack
);

  localparam bit unused_family = (C_FAMILY == "");

  logic     start;
  logic     xfer_ack;
  opb_req_t req;

  opb_slave_ack_fsm #(
    .C_BASEADDR  (C_BASEADDR),
    .C_HIGHADDR  (C_HIGHADDR),
    .C_OPB_AWIDTH(C_OPB_AWIDTH)
  ) u_fsm (
    .clk_i     (OPB_Clk),
    .rst_ni    (OPB_Rst_n),
    .addr_i    (OPB_ABus),
    .select_i  (OPB_select),
    .rnw_i     (OPB_RNW),
    .be_any_i  (|OPB_BE),
    .start_o   (start),
    .xfer_ack_o(xfer_ack),
    .req_o     (req)
  );

  logic [31:0]      holding_q, holding_d;
  logic             fresh_q, fresh_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic [31:0]      rdata_q, rd_val;
  logic             data_rd_ack, status_clr;

  assign data_rd_ack = xfer_ack && req.rnw && (req.word == WORD_DATA);
  assign status_clr  = xfer_ack && !req.rnw && (req.word == WORD_STATUS) && req.be_any;

  always_comb begin
    holding_d = holding_q;
    fresh_d   = fresh_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;
    if (data_rd_ack) fresh_d = 1'b0;
    if (user_valid) begin
      holding_d = user_data_in;
      fresh_d   = 1'b1;
      cnt_d     = cnt_q + 32'd1;
      // A capture landing on the consuming read is not an overrun.
      if (fresh_q && !data_rd_ack && (ovr_q != '1)) ovr_d = ovr_q + 1'b1;
    end
    if (status_clr) ovr_d = '0;
  end

  always_comb begin
    rd_val = '0;
    case (OPB_ABus[C_OPB_AWIDTH-4 +: 2])
      WORD_DATA:   rd_val = holding_q;
      WORD_STATUS: rd_val = status_word(ovr_q, fresh_q);
      WORD_COUNT:  rd_val = cnt_q;
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      holding_q <= '0;
      fresh_q   <= 1'b0;
      cnt_q     <= '0;
      ovr_q     <= '0;
      rdata_q   <= '0;
    end else begin
      holding_q <= holding_d;
      fresh_q   <= fresh_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
      // Loaded only on acceptance, so the bus is non-zero only during ACK.
      rdata_q   <= start ? rd_val : '0;
    end
  end

  assign Sl_DBus     = rdata_q;
  assign Sl_xferAck  = xfer_ack;
  assign user_rd_ack = data_rd_ack;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, OPB_DBus, unused_family};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Directed bench: bus reads are scored against a queue of expected words
// filled from a small reference model of the snapshot registers.
module tb_opb_register_simulink2ppc_snap;

  localparam logic [31:0] BASE = 32'h01180100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus_w;
  logic        rnw, sel, seqa;
  logic [0:31] sl_dbus;
  logic        sl_err, sl_retry, sl_tout, sl_ack;
  logic [31:0] udata;
  logic        uvalid, urdack;

  always #5 clk = ~clk;

  opb_register_simulink2ppc_snap dut (
    .OPB_Clk     (clk),
    .OPB_Rst_n   (rst_n),
    .OPB_ABus    (abus),
    .OPB_BE      (be),
    .OPB_DBus    (dbus_w),
    .OPB_RNW     (rnw),
    .OPB_select  (sel),
    .OPB_seqAddr (seqa),
    .Sl_DBus     (sl_dbus),
    .Sl_errAck   (sl_err),
    .Sl_retry    (sl_retry),
    .Sl_toutSup  (sl_tout),
    .Sl_xferAck  (sl_ack),
    .user_data_in(udata),
    .user_valid  (uvalid),
    .user_rd_ack (urdack)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb_q[$];

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_hold, m_cnt;
  logic [15:0] m_ovr;
  logic        m_fresh;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = '0; m_cnt = '0; m_ovr = '0; m_fresh = 1'b0;
  endtask

  task automatic capture(input logic [31:0] d);
    @(negedge clk);
    uvalid = 1'b1; udata = d;
    @(negedge clk);
    uvalid = 1'b0;
    if (m_fresh && m_ovr != 16'hFFFF) m_ovr++;
    m_hold = d; m_fresh = 1'b1; m_cnt++;
  endtask

  task automatic opb_read(input logic [31:0] addr, input logic [31:0] exp, input string tag,
                          input logic exp_rdack, input logic coin_v, input logic [31:0] coin_d);
    sb_t e;
    bit  got;
    sb_q.push_back('{tag, exp});
    @(negedge clk);
    abus = addr; rnw = 1'b1; sel = 1'b1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (sl_ack) got = 1;
    end
    sel = 1'b0; abus = '0;
    e = sb_q.pop_front();
    if (!got) begin
      chk({e.tag, "_timeout"}, 0, 1);
    end else begin
      chk(e.tag, sl_dbus, e.val);
      chk({e.tag, "_rdack"}, urdack, exp_rdack);
      if (coin_v) begin uvalid = 1'b1; udata = coin_d; end
      @(negedge clk);
      uvalid = 1'b0;
      chk({e.tag, "_post"}, {sl_ack, urdack, sl_dbus}, 0);
    end
  endtask

  task automatic opb_write(input logic [31:0] addr, input logic [3:0] bes, input string tag);
    bit got;
    @(negedge clk);
    abus = addr; rnw = 1'b0; sel = 1'b1; be = bes; dbus_w = '0;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (sl_ack) got = 1;
    end
    sel = 1'b0; abus = '0; be = '0; rnw = 1'b1;
    chk({tag, "_ack"}, got, 1);
    @(negedge clk);
    if (addr == BASE + 4 && bes != 0) m_ovr = '0;
  endtask

  task automatic rd_data(input string tag);
    opb_read(BASE, m_hold, tag, 1'b1, 1'b0, '0);
    m_fresh = 1'b0;
  endtask

  task automatic rd_status(input string tag);
    opb_read(BASE + 4, {m_ovr, 15'b0, m_fresh}, tag, 1'b0, 1'b0, '0);
  endtask

  task automatic rd_count(input string tag);
    opb_read(BASE + 8, m_cnt, tag, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int nack;
    logic [31:0] dbus_or;
    bit got;
    rst_n = 1'b0; abus = '0; be = '0; dbus_w = '0; rnw = 1'b1; sel = 1'b0; seqa = 1'b0;
    udata = 32'hAAAA5555; uvalid = 1'b1;
    model_reset();

    // Reset with user_valid held high: must be ignored.
    repeat (3) @(negedge clk);
    chk("rst_outs", {sl_ack, urdack, sl_err, sl_retry, sl_tout, sl_dbus}, 0);
    uvalid = 1'b0;
    rst_n = 1'b1;

    opb_read(BASE, 32'h0, "rst_data", 1'b1, 1'b0, '0);
    rd_status("rst_status");
    rd_count("rst_count");
    opb_read(BASE + 12, 32'h0, "word3", 1'b0, 1'b0, '0);

    capture(32'hDEADBEEF);
    rd_data("data_beef");
    rd_status("status_after_rd");
    rd_count("count_1");

    repeat (3) capture($urandom);
    rd_status("status_ovr2");
    chk("status_ovr2_const", {m_ovr, 15'b0, m_fresh}, 32'h00020001);
    opb_write(BASE + 4, 4'h0, "wr_be0");
    rd_status("status_be0");
    opb_write(BASE, 4'hF, "wr_data");
    rd_status("status_wr_data");
    opb_write(BASE + 4, 4'hF, "wr_clr");
    rd_status("status_clr");

    // Capture landing on the ACK of the consuming DATA read.
    capture(32'h11);
    rd_status("status_pre_coin");
    opb_read(BASE, 32'h11, "coin_data", 1'b1, 1'b1, 32'h22);
    m_hold = 32'h22; m_cnt++;
    rd_status("status_coin");
    rd_data("data_22");
    rd_count("count_coin");

    // Select held on an address below the window.
    @(negedge clk);
    abus = 32'h01180000; rnw = 1'b1; sel = 1'b1;
    nack = 0; dbus_or = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sl_ack) nack++;
      dbus_or |= sl_dbus;
    end
    sel = 1'b0; abus = '0;
    chk("oor_ack", nack, 0);
    chk("oor_dbus", dbus_or, 0);

    // Counter wrap and overrun saturation.
    @(negedge clk);
    force dut.cnt_q = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.cnt_q;
    m_cnt = 32'hFFFFFFFF;
    capture(32'h5A5A0001);
    rd_count("count_wrap");
    chk("count_wrap_const", m_cnt, 0);
    @(negedge clk);
    force dut.ovr_q = 16'hFFFF;
    @(negedge clk);
    release dut.ovr_q;
    m_ovr = 16'hFFFF;
    capture(32'h5A5A0002);
    rd_status("status_sat");
    opb_write(BASE + 4, 4'h1, "wr_clr2");
    rd_status("status_clr2");

    // Reset during ACK aborts the transfer.
    @(negedge clk);
    abus = BASE + 8; rnw = 1'b1; sel = 1'b1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (sl_ack) got = 1;
    end
    chk("abort_ack_seen", got, 1);
    rst_n = 1'b0; sel = 1'b0; abus = '0;
    @(negedge clk);
    chk("abort_no_ack", {sl_ack, sl_dbus}, 0);
    rst_n = 1'b1;
    model_reset();
    rd_status("status_after_abort");
    rd_count("count_after_abort");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
